// File: rtl/regfile_multiport_pkg.sv
// rtl/regfile_multiport_pkg.sv - shared defaults and encodings for the multiport register file
package regfile_multiport_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;

  // Register 0 is the hardwired-zero register.
  localparam int REG_ZERO = 0;

  // Read latency encodings.
  localparam int READ_COMB = 0;
  localparam int READ_REG  = 1;

  // Low bit of element idx in a packed vector of w-bit elements.
  function automatic int slice_lo(input int idx, input int w);
    return idx * w;
  endfunction

endpackage

// File: rtl/regfile_multiport_if.sv
// rtl/regfile_multiport_if.sv - write, busy-set and read-port bundle of the register file
interface regfile_multiport_if #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_READ = 2
);

  logic                         ctrl_writeEnable;
  logic [ADDR_W-1:0]            ctrl_writeReg;
  logic [DATA_W-1:0]            data_writeReg;
  logic                         ctrl_busySet;
  logic [ADDR_W-1:0]            ctrl_busyReg;
  logic [NUM_READ-1:0]          ctrl_readEnable;
  logic [NUM_READ*ADDR_W-1:0]   ctrl_readReg;
  logic [NUM_READ*DATA_W-1:0]   data_readReg;
  logic [NUM_READ-1:0]          read_busy;
  logic [NUM_READ-1:0]          read_valid;

  modport master (
    output ctrl_writeEnable, ctrl_writeReg, data_writeReg,
    output ctrl_busySet, ctrl_busyReg,
    output ctrl_readEnable, ctrl_readReg,
    input  data_readReg, read_busy, read_valid
  );

  modport slave (
    input  ctrl_writeEnable, ctrl_writeReg, data_writeReg,
    input  ctrl_busySet, ctrl_busyReg,
    input  ctrl_readEnable, ctrl_readReg,
    output data_readReg, read_busy, read_valid
  );

endinterface

// File: rtl/regfile_read_port.sv
// rtl/regfile_read_port.sv - one read port: address mux, write bypass, busy lookup, optional output register
module regfile_read_port
  import regfile_multiport_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int READ_LAT = READ_COMB,
  parameter int BYPASS   = 1
) (
  input  logic                  clock,
  input  logic                  ctrl_reset,
  input  logic [DATA_W-1:0]     regs [2**ADDR_W],
  input  logic [2**ADDR_W-1:0]  busy,
  input  logic                  write_en,
  input  logic [ADDR_W-1:0]     write_reg,
  input  logic [DATA_W-1:0]     write_data,
  input  logic                  busy_set,
  input  logic [ADDR_W-1:0]     busy_reg,
  input  logic                  read_en,
  input  logic [ADDR_W-1:0]     read_reg,
  output logic [DATA_W-1:0]     read_data,
  output logic                  read_busy,
  output logic                  read_valid
);

  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO);

  logic              bypass_hit;
  logic [DATA_W-1:0] res_data;
  logic              res_busy;

  // Resolve data/busy for the addressed register, forwarding a same-cycle write.
  always_comb begin
    res_data   = '0;
    res_busy   = 1'b0;
    bypass_hit = (BYPASS != 0) && write_en && (write_reg == read_reg) && (read_reg != ZERO_ADDR);
    if (read_reg == ZERO_ADDR) begin
      res_data = '0;
      res_busy = 1'b0;
    end else if (bypass_hit) begin
      res_data = write_data;
      res_busy = busy_set && (busy_reg == read_reg);
    end else begin
      res_data = regs[read_reg];
      res_busy = busy[read_reg];
    end
  end

  generate
    if (READ_LAT == READ_REG) begin : g_reg
      // Capture the resolved read on an enabled edge; hold data/busy otherwise.
      always_ff @(posedge clock or posedge ctrl_reset) begin
        if (ctrl_reset) begin
          read_data  <= '0;
          read_busy  <= 1'b0;
          read_valid <= 1'b0;
        end else begin
          read_valid <= read_en;
          if (read_en) begin
            read_data <= res_data;
            read_busy <= res_busy;
          end
        end
      end
    end else begin : g_comb
      logic unused_clk_rst;
      assign unused_clk_rst = clock ^ ctrl_reset;
      assign read_data  = res_data;
      assign read_busy  = res_busy;
      assign read_valid = read_en;
    end
  endgenerate

endmodule

// File: rtl/regfile_multiport.sv
// rtl/regfile_multiport.sv - register file with one write port, NUM_READ read ports and busy scoreboard
module regfile_multiport
  import regfile_multiport_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int NUM_READ = 2,
  parameter int READ_LAT = READ_COMB,
  parameter int BYPASS   = 1
) (
  input  logic                clock,
  input  logic                ctrl_reset,
  regfile_multiport_if.slave  bus
);

  localparam int                NREG      = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO);

  logic [DATA_W-1:0] regs [NREG];
  logic [NREG-1:0]   busy;

  logic write_ok;
  logic busy_ok;

  assign write_ok = bus.ctrl_writeEnable && (bus.ctrl_writeReg != ZERO_ADDR);
  assign busy_ok  = bus.ctrl_busySet && (bus.ctrl_busyReg != ZERO_ADDR);

  // Storage update; r0 is never written so it stays at its reset value of 0.
  always_ff @(posedge clock or posedge ctrl_reset) begin
    if (ctrl_reset) begin
      for (int r = 0; r < NREG; r++) regs[r] <= '0;
    end else if (write_ok) begin
      regs[bus.ctrl_writeReg] <= bus.data_writeReg;
    end
  end

  // Scoreboard: writeback clears, busy-set marks; a same-cycle set on the same register wins.
  always_ff @(posedge clock or posedge ctrl_reset) begin
    if (ctrl_reset) begin
      busy <= '0;
    end else begin
      if (write_ok) busy[bus.ctrl_writeReg] <= 1'b0;
      if (busy_ok)  busy[bus.ctrl_busyReg]  <= 1'b1;
    end
  end

  generate
    for (genvar i = 0; i < NUM_READ; i++) begin : g_port
      regfile_read_port #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .READ_LAT (READ_LAT),
        .BYPASS   (BYPASS)
      ) u_port (
        .clock      (clock),
        .ctrl_reset (ctrl_reset),
        .regs       (regs),
        .busy       (busy),
        .write_en   (bus.ctrl_writeEnable),
        .write_reg  (bus.ctrl_writeReg),
        .write_data (bus.data_writeReg),
        .busy_set   (bus.ctrl_busySet),
        .busy_reg   (bus.ctrl_busyReg),
        .read_en    (bus.ctrl_readEnable[i]),
        .read_reg   (bus.ctrl_readReg[slice_lo(i, ADDR_W) +: ADDR_W]),
        .read_data  (bus.data_readReg[slice_lo(i, DATA_W) +: DATA_W]),
        .read_busy  (bus.read_busy[i]),
        .read_valid (bus.read_valid[i])
      );
    end
  endgenerate

endmodule
